// File: rtl/ysyx_23060124_lsu_bus_pkg.sv
// Shared definitions for the LSU bus back end: operation codes, AXI
// response codes and the controller state encoding.
package ysyx_23060124_lsu_bus_pkg;

  localparam int ISA_WIDTH = 32;
  localparam int OPT_WIDTH = 4;

  // Load operation codes carried on load_opt
  localparam logic [OPT_WIDTH-1:0] OPT_LSU_NONE = 4'd0;
  localparam logic [OPT_WIDTH-1:0] OPT_LSU_LB   = 4'd1;
  localparam logic [OPT_WIDTH-1:0] OPT_LSU_LH   = 4'd2;
  localparam logic [OPT_WIDTH-1:0] OPT_LSU_LW   = 4'd3;
  localparam logic [OPT_WIDTH-1:0] OPT_LSU_LBU  = 4'd4;
  localparam logic [OPT_WIDTH-1:0] OPT_LSU_LHU  = 4'd5;

  // Store operation codes carried on store_opt
  localparam logic [OPT_WIDTH-1:0] OPT_LSU_SB   = 4'd1;
  localparam logic [OPT_WIDTH-1:0] OPT_LSU_SH   = 4'd2;
  localparam logic [OPT_WIDTH-1:0] OPT_LSU_SW   = 4'd3;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RESP
  } lsu_state_e;

endpackage

// File: rtl/ysyx_23060124_lsu_bus_if.sv
// Bundles the LSU request, write-back response and AXI4-Lite channels.
// "master" is the view of the LSU back end; "slave" is the environment
// (LSU stage, WBU and memory) that talks to it.
interface ysyx_23060124_lsu_bus_if;
  import ysyx_23060124_lsu_bus_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [ISA_WIDTH-1:0] req_addr;
  logic [ISA_WIDTH-1:0] req_wdata;
  logic [OPT_WIDTH-1:0] load_opt;
  logic [OPT_WIDTH-1:0] store_opt;

  logic                 resp_valid;
  logic                 resp_ready;
  logic [ISA_WIDTH-1:0] resp_rdata;
  logic                 resp_err;

  logic [ISA_WIDTH-1:0] araddr;
  logic                 arvalid;
  logic                 arready;
  logic [ISA_WIDTH-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  logic [ISA_WIDTH-1:0] awaddr;
  logic                 awvalid;
  logic                 awready;
  logic [ISA_WIDTH-1:0] wdata;
  logic [3:0]           wstrb;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;

  modport master (
    input  req_valid, req_addr, req_wdata, load_opt, store_opt, resp_ready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
  );

  modport slave (
    output req_valid, req_addr, req_wdata, load_opt, store_opt, resp_ready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
  );

endinterface

// File: rtl/ysyx_23060124_lsu_align.sv
// Byte-lane alignment for the LSU: store data/strobe placement, load data
// extraction with sign/zero extension, and request legality checking.
module ysyx_23060124_lsu_align
  import ysyx_23060124_lsu_bus_pkg::*;
(
  input  logic [1:0]           off,
  input  logic [OPT_WIDTH-1:0] load_opt,
  input  logic [OPT_WIDTH-1:0] store_opt,
  input  logic [ISA_WIDTH-1:0] store_src,
  input  logic [ISA_WIDTH-1:0] bus_rdata,
  output logic [ISA_WIDTH-1:0] bus_wdata,
  output logic [3:0]           bus_wstrb,
  output logic [ISA_WIDTH-1:0] load_data,
  output logic                 req_err
);

  logic [ISA_WIDTH-1:0] sh;

  assign sh        = bus_rdata >> {off, 3'b000};
  assign bus_wdata = store_src << {off, 3'b000};

  // Byte strobes follow the store size, shifted to the addressed lane
  always_comb begin
    bus_wstrb = 4'b0000;
    case (store_opt)
      OPT_LSU_SB: bus_wstrb = 4'b0001 << off;
      OPT_LSU_SH: bus_wstrb = 4'b0011 << off;
      OPT_LSU_SW: bus_wstrb = 4'b1111;
      default:    bus_wstrb = 4'b0000;
    endcase
  end

  // Extract the addressed byte/half and extend it to a full word
  always_comb begin
    load_data = sh;
    case (load_opt)
      OPT_LSU_LB:  load_data = {{24{sh[7]}}, sh[7:0]};
      OPT_LSU_LBU: load_data = {24'h0, sh[7:0]};
      OPT_LSU_LH:  load_data = {{16{sh[15]}}, sh[15:0]};
      OPT_LSU_LHU: load_data = {16'h0, sh[15:0]};
      default:     load_data = sh;
    endcase
  end

  // Unknown codes, load+store together, or a misaligned half/word are rejected
  always_comb begin
    req_err = 1'b0;
    if (load_opt > OPT_LSU_LHU || store_opt > OPT_LSU_SW)
      req_err = 1'b1;
    if (load_opt != OPT_LSU_NONE && store_opt != OPT_LSU_NONE)
      req_err = 1'b1;
    if ((load_opt == OPT_LSU_LH || load_opt == OPT_LSU_LHU || store_opt == OPT_LSU_SH) && off[0])
      req_err = 1'b1;
    if ((load_opt == OPT_LSU_LW || store_opt == OPT_LSU_SW) && off != 2'b00)
      req_err = 1'b1;
  end

endmodule

// File: rtl/ysyx_23060124_lsu_bus.sv
// LSU memory back end: accepts one load/store request, runs it as a single
// AXI4-Lite transaction and returns the (extended) result to write-back.
module ysyx_23060124_lsu_bus
  import ysyx_23060124_lsu_bus_pkg::*;
(
  input logic                     i_clk,
  input logic                     i_rst,
  ysyx_23060124_lsu_bus_if.master bus
);

  lsu_state_e           state_reg, state_next;
  logic [ISA_WIDTH-1:0] addr_reg, addr_next;
  logic [ISA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [OPT_WIDTH-1:0] load_opt_reg, load_opt_next;
  logic [OPT_WIDTH-1:0] store_opt_reg, store_opt_next;
  logic                 aw_done_reg, aw_done_next;
  logic                 w_done_reg, w_done_next;
  logic [ISA_WIDTH-1:0] rdata_reg, rdata_next;
  logic                 err_reg, err_next;

  logic                 idle;
  logic [1:0]           sel_off;
  logic [OPT_WIDTH-1:0] sel_load_opt;
  logic [OPT_WIDTH-1:0] sel_store_opt;
  logic [ISA_WIDTH-1:0] align_wdata;
  logic [3:0]           align_wstrb;
  logic [ISA_WIDTH-1:0] align_load;
  logic                 align_err;
  logic                 aw_ok;
  logic                 w_ok;

  assign idle = (state_reg == ST_IDLE);

  // The aligner checks the incoming request while idle and works on the
  // captured request for the rest of the transaction.
  assign sel_off       = idle ? bus.req_addr[1:0] : addr_reg[1:0];
  assign sel_load_opt  = idle ? bus.load_opt      : load_opt_reg;
  assign sel_store_opt = idle ? bus.store_opt     : store_opt_reg;

  ysyx_23060124_lsu_align u_align (
    .off       (sel_off),
    .load_opt  (sel_load_opt),
    .store_opt (sel_store_opt),
    .store_src (wdata_reg),
    .bus_rdata (bus.rdata),
    .bus_wdata (align_wdata),
    .bus_wstrb (align_wstrb),
    .load_data (align_load),
    .req_err   (align_err)
  );

  // A write channel counts as done once its handshake has happened, either
  // in an earlier cycle or in this one.
  assign aw_ok = aw_done_reg | bus.awready;
  assign w_ok  = w_done_reg  | bus.wready;

  assign bus.req_ready  = idle;
  assign bus.araddr     = {addr_reg[ISA_WIDTH-1:2], 2'b00};
  assign bus.arvalid    = (state_reg == ST_RD_ADDR);
  assign bus.rready     = (state_reg == ST_RD_DATA);
  assign bus.awaddr     = {addr_reg[ISA_WIDTH-1:2], 2'b00};
  assign bus.awvalid    = (state_reg == ST_WR_REQ) && !aw_done_reg;
  assign bus.wdata      = align_wdata;
  assign bus.wstrb      = align_wstrb;
  assign bus.wvalid     = (state_reg == ST_WR_REQ) && !w_done_reg;
  assign bus.bready     = (state_reg == ST_WR_RESP);
  assign bus.resp_valid = (state_reg == ST_RESP);
  assign bus.resp_rdata = rdata_reg;
  assign bus.resp_err   = err_reg;

  // State and captured request/response registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      load_opt_reg  <= '0;
      store_opt_reg <= '0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      load_opt_reg  <= load_opt_next;
      store_opt_reg <= store_opt_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
    end
  end

  // Transaction sequencing: decode on accept, drive one AXI transfer, respond
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    load_opt_next  = load_opt_reg;
    store_opt_next = store_opt_reg;
    aw_done_next   = aw_done_reg;
    w_done_next    = w_done_reg;
    rdata_next     = rdata_reg;
    err_next       = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_next      = bus.req_addr;
          wdata_next     = bus.req_wdata;
          load_opt_next  = bus.load_opt;
          store_opt_next = bus.store_opt;
          aw_done_next   = 1'b0;
          w_done_next    = 1'b0;
          rdata_next     = '0;
          err_next       = 1'b0;
          if (align_err) begin
            err_next   = 1'b1;
            state_next = ST_RESP;
          end else if (bus.load_opt != OPT_LSU_NONE) begin
            state_next = ST_RD_ADDR;
          end else if (bus.store_opt != OPT_LSU_NONE) begin
            state_next = ST_WR_REQ;
          end else begin
            state_next = ST_RESP;
          end
        end
      end
      ST_RD_ADDR: begin
        if (bus.arready) state_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (bus.rvalid) begin
          rdata_next = align_load;
          err_next   = (bus.rresp != AXI_RESP_OKAY);
          state_next = ST_RESP;
        end
      end
      ST_WR_REQ: begin
        aw_done_next = aw_ok;
        w_done_next  = w_ok;
        if (aw_ok && w_ok) state_next = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (bus.bvalid) begin
          err_next   = (bus.bresp != AXI_RESP_OKAY);
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060124_lsu_bus.sv
// Randomized scoreboard bench for the LSU bus back end with an AXI-Lite
// slave model and a byte-level reference model of loads and stores.
module tb_ysyx_23060124_lsu_bus;
  import ysyx_23060124_lsu_bus_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [1:0]  bresp;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ar_lat, r_lat, aw_lat, w_lat, b_lat;
  } plan_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_23060124_lsu_bus_if bus ();

  ysyx_23060124_lsu_bus dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int    vectors = 0;
  int    miscompares = 0;
  int    ar_hs = 0;
  int    aw_hs = 0;
  int    w_hs = 0;
  int    txn_id = 0;
  exp_t  exp_q[$];
  plan_t plan_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference behaviour expressed per byte lane.
  // kind: 0 = no bus traffic, 1 = read, 2 = write
  task automatic ref_model(input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] lo, input logic [3:0] so,
                           input logic [31:0] rd, input logic [1:0] rr, input logic [1:0] br,
                           output int kind, output logic [31:0] e_rdata, output logic e_err,
                           output logic [31:0] e_wdata, output logic [3:0] e_strb);
    int          off;
    int          size;
    logic [63:0] v;
    logic [31:0] b;
    off = int'(addr[1:0]);
    kind = 0; e_rdata = 0; e_err = 0; e_wdata = 0; e_strb = 0;
    if (lo > 5 || so > 3 || (lo != 0 && so != 0)) begin
      e_err = 1'b1;
      return;
    end
    if (lo == 0 && so == 0) return;
    if (lo != 0) size = (lo == 1 || lo == 4) ? 1 : (lo == 2 || lo == 5) ? 2 : 4;
    else         size = (so == 1) ? 1 : (so == 2) ? 2 : 4;
    if (off % size != 0) begin
      e_err = 1'b1;
      return;
    end
    if (lo != 0) begin
      kind = 1;
      v = 64'd0;
      for (int k = 0; k < size; k++) begin
        b = (rd >> (8 * (off + k))) & 32'hff;
        v = v | (64'(b) << (8 * k));
      end
      if ((lo == 1 || lo == 2) && v[8*size-1]) v = v - (64'd1 << (8 * size));
      e_rdata = v[31:0];
      e_err = (rr != 2'd0);
    end else begin
      kind = 2;
      for (int k = 0; k < size; k++) begin
        b = (wd >> (8 * k)) & 32'hff;
        e_wdata = e_wdata | (b << (8 * (off + k)));
        e_strb[off + k] = 1'b1;
      end
      e_err = (br != 2'd0);
    end
  endtask

  task automatic slave_clear();
    bus.arready = 0; bus.rvalid = 0; bus.rresp = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
  endtask

  task automatic slave_read(input plan_t p);
    for (int i = 0; i < p.ar_lat; i++) begin
      chk("arvalid_hold", 32'(bus.arvalid), 32'd1);
      chk("araddr_stable", bus.araddr, p.addr);
      @(posedge clk); #1;
      if (rst) begin slave_clear(); return; end
    end
    chk("araddr", bus.araddr, p.addr);
    bus.arready = 1;
    @(posedge clk); #1;
    bus.arready = 0;
    ar_hs++;
    if (rst) begin slave_clear(); return; end
    for (int i = 0; i < p.r_lat; i++) begin
      chk("ar_once", 32'(bus.arvalid), 32'd0);
      @(posedge clk); #1;
      if (rst) begin slave_clear(); return; end
    end
    chk("ar_once", 32'(bus.arvalid), 32'd0);
    chk("rready", 32'(bus.rready), 32'd1);
    bus.rvalid = 1; bus.rdata = p.rdata; bus.rresp = p.rresp;
    @(posedge clk); #1;
    bus.rvalid = 0; bus.rdata = $urandom; bus.rresp = 0;
  endtask

  task automatic slave_write(input plan_t p);
    logic [31:0] mask;
    bit aw_done, w_done, aw_fire, w_fire;
    int t;
    mask = {{8{p.wstrb[3]}}, {8{p.wstrb[2]}}, {8{p.wstrb[1]}}, {8{p.wstrb[0]}}};
    chk("awvalid_rise", 32'(bus.awvalid), 32'd1);
    chk("wvalid_rise", 32'(bus.wvalid), 32'd1);
    aw_done = 0; w_done = 0; t = 0;
    while (!(aw_done && w_done) && t < 100) begin
      aw_fire = 0; w_fire = 0;
      if (!aw_done) begin
        if (t >= p.aw_lat) begin
          chk("awvalid_hold", 32'(bus.awvalid), 32'd1);
          chk("awaddr", bus.awaddr, p.addr);
          bus.awready = 1; aw_fire = 1;
        end
      end else chk("aw_once", 32'(bus.awvalid), 32'd0);
      if (!w_done) begin
        if (t >= p.w_lat) begin
          chk("wvalid_hold", 32'(bus.wvalid), 32'd1);
          chk("wdata", bus.wdata & mask, p.wdata);
          chk("wstrb", 32'(bus.wstrb), 32'(p.wstrb));
          bus.wready = 1; w_fire = 1;
        end
      end else chk("w_once", 32'(bus.wvalid), 32'd0);
      @(posedge clk); #1;
      bus.awready = 0; bus.wready = 0;
      if (rst) begin slave_clear(); return; end
      if (aw_fire) begin aw_done = 1; aw_hs++; end
      if (w_fire) begin w_done = 1; w_hs++; end
      t++;
    end
    for (int i = 0; i < p.b_lat; i++) begin
      chk("aw_once", 32'(bus.awvalid), 32'd0);
      chk("w_once", 32'(bus.wvalid), 32'd0);
      @(posedge clk); #1;
      if (rst) begin slave_clear(); return; end
    end
    chk("aw_once", 32'(bus.awvalid), 32'd0);
    chk("bready", 32'(bus.bready), 32'd1);
    bus.bvalid = 1; bus.bresp = p.bresp;
    @(posedge clk); #1;
    bus.bvalid = 0; bus.bresp = 0;
  endtask

  // AXI-Lite slave: serves each transaction from the plan queue
  initial begin
    slave_clear();
    bus.rdata = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        slave_clear();
        continue;
      end
      if (bus.arvalid) begin
        if (plan_q.size() == 0 || plan_q[0].is_write) begin
          chk("unexpected_ar", 32'(bus.arvalid), 32'd0);
        end else slave_read(plan_q.pop_front());
      end else if (bus.awvalid || bus.wvalid) begin
        if (plan_q.size() == 0 || !plan_q[0].is_write) begin
          chk("unexpected_aw_w", 32'(bus.awvalid | bus.wvalid), 32'd0);
        end else slave_write(plan_q.pop_front());
      end
    end
  end

  // Response monitor: compares every WBU handshake against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'(bus.resp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(e.err));
        $display("txn %0d addr=%h rdata=%h err=%0d", txn_id, e.addr, bus.resp_rdata, bus.resp_err);
        txn_id++;
      end
    end
  end

  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] lo, input logic [3:0] so,
                        input logic [31:0] rd, input logic [1:0] rr, input logic [1:0] br,
                        input int ar_lat, input int r_lat, input int aw_lat, input int w_lat,
                        input int b_lat, input int resp_delay, output int lat);
    int          kind;
    int          waited;
    logic [31:0] e_rdata, e_wdata, r0;
    logic        e_err, e0;
    logic [3:0]  e_strb;
    plan_t       p;
    exp_t        e;
    ref_model(addr, wd, lo, so, rd, rr, br, kind, e_rdata, e_err, e_wdata, e_strb);
    e.addr = addr; e.rdata = e_rdata; e.err = e_err;
    exp_q.push_back(e);
    if (kind != 0) begin
      p.is_write = (kind == 2);
      p.addr = {addr[31:2], 2'b00};
      p.rdata = rd; p.rresp = rr; p.bresp = br;
      p.wdata = e_wdata; p.wstrb = e_strb;
      p.ar_lat = ar_lat; p.r_lat = r_lat; p.aw_lat = aw_lat; p.w_lat = w_lat; p.b_lat = b_lat;
      plan_q.push_back(p);
    end
    bus.req_valid = 1; bus.req_addr = addr; bus.req_wdata = wd;
    bus.load_opt = lo; bus.store_opt = so;
    waited = 0;
    while (!bus.req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 0; bus.load_opt = 0; bus.store_opt = 0;
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
    lat = 1;
    while (!bus.resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.resp_valid) begin
      chk("resp_timeout", 32'(bus.resp_valid), 32'd1);
      return;
    end
    r0 = bus.resp_rdata; e0 = bus.resp_err;
    for (int i = 0; i < resp_delay; i++) begin
      @(posedge clk); #1;
      chk("resp_valid_hold", 32'(bus.resp_valid), 32'd1);
      chk("resp_rdata_hold", bus.resp_rdata, r0);
      chk("resp_err_hold", 32'(bus.resp_err), 32'(e0));
      chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1;
    @(posedge clk); #1;
    bus.resp_ready = 0;
    chk("req_ready_next", 32'(bus.req_ready), 32'd1);
  endtask

  // Watchdog so the run always ends
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Directed cases followed by randomized traffic
  initial begin
    int          lat, ar0, aw0, w0, k, waited;
    logic [3:0]  lo, so;
    logic [31:0] addr;
    logic [1:0]  rr, br;
    bus.req_valid = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.load_opt = 0; bus.store_opt = 0; bus.resp_ready = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("rst_awvalid", 32'(bus.awvalid), 32'd0);
    chk("rst_wvalid", 32'(bus.wvalid), 32'd0);
    chk("rst_rready", 32'(bus.rready), 32'd0);
    chk("rst_bready", 32'(bus.bready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    rst = 0;

    // Byte loads with 2-cycle read-data latency
    do_txn(32'h8000_0003, 0, OPT_LSU_LB, 0, 32'h80FF_1234, 0, 0, 0, 2, 0, 0, 0, 0, lat);
    do_txn(32'h8000_0003, 0, OPT_LSU_LBU, 0, 32'h80FF_1234, 0, 0, 0, 2, 0, 0, 0, 0, lat);
    // Halfword store to upper lanes
    do_txn(32'h8000_0002, 32'h0000_ABCD, 0, OPT_LSU_SH, 0, 0, 0, 0, 0, 0, 0, 1, 0, lat);
    // W ready three cycles ahead of AW, then both in the same cycle
    aw0 = aw_hs; w0 = w_hs;
    do_txn(32'h8000_0010, 32'h1122_3344, 0, OPT_LSU_SW, 0, 0, 0, 0, 0, 3, 0, 0, 0, lat);
    chk("aw_beats_split", 32'(aw_hs - aw0), 32'd1);
    chk("w_beats_split", 32'(w_hs - w0), 32'd1);
    aw0 = aw_hs; w0 = w_hs;
    do_txn(32'h8000_0014, 32'h5566_7788, 0, OPT_LSU_SW, 0, 0, 0, 0, 0, 2, 2, 0, 0, lat);
    chk("aw_beats_same", 32'(aw_hs - aw0), 32'd1);
    chk("w_beats_same", 32'(w_hs - w0), 32'd1);
    // Misaligned word load and illegal load+store combination: no bus traffic
    ar0 = ar_hs; aw0 = aw_hs;
    do_txn(32'h8000_0001, 0, OPT_LSU_LW, 0, $urandom, 0, 0, 0, 0, 0, 0, 0, 0, lat);
    chk("misalign_latency", 32'(lat), 32'd1);
    chk("misalign_no_ar", 32'(ar_hs - ar0), 32'd0);
    do_txn(32'h8000_0020, 32'hDEAD_BEEF, OPT_LSU_LB, OPT_LSU_SW, 0, 0, 0, 0, 0, 0, 0, 0, 0, lat);
    chk("both_latency", 32'(lat), 32'd1);
    chk("both_no_aw", 32'(aw_hs - aw0), 32'd0);
    // Response backpressure, then a slave error
    do_txn(32'h8000_0024, 0, OPT_LSU_LW, 0, 32'hCAFE_F00D, 0, 0, 1, 1, 0, 0, 0, 5, lat);
    do_txn(32'h8000_0028, 0, OPT_LSU_LHU, 0, 32'h1234_8765, AXI_RESP_SLVERR, 0, 0, 0, 0, 0, 0, 0, lat);
    // Minimum read latency
    do_txn(32'h8000_002C, 0, OPT_LSU_LW, 0, 32'h0BAD_CAFE, 0, 0, 0, 0, 0, 0, 0, 0, lat);
    chk("min_latency", 32'(lat), 32'd3);
    // Empty request
    do_txn(32'h8000_0030, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, lat);

    // Reset while waiting for read data
    begin
      plan_t p;
      p.is_write = 0; p.addr = 32'h8000_0040; p.rdata = 32'h1357_9BDF; p.rresp = 0; p.bresp = 0;
      p.wdata = 0; p.wstrb = 0; p.ar_lat = 0; p.r_lat = 20; p.aw_lat = 0; p.w_lat = 0; p.b_lat = 0;
      plan_q.push_back(p);
    end
    bus.req_valid = 1; bus.req_addr = 32'h8000_0040; bus.load_opt = OPT_LSU_LW; bus.store_opt = 0;
    @(posedge clk); #1;
    bus.req_valid = 0; bus.load_opt = 0;
    waited = 0;
    while (!bus.rready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("rst_mid_reached_rdata", 32'(bus.rready), 32'd1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_rready", 32'(bus.rready), 32'd0);
    chk("rst_mid_arvalid", 32'(bus.arvalid), 32'd0);
    chk("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    rst = 0;
    plan_q.delete();
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid_no_resp", 32'(bus.resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    do_txn(32'h8000_0044, 0, OPT_LSU_LW, 0, 32'h2468_ACE0, 0, 0, 1, 1, 0, 0, 0, 0, lat);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      lo = 0; so = 0;
      if (k < 5) lo = 4'(k + 1);
      else if (k < 8) so = 4'(k - 4);
      else if (k == 9) begin
        lo = 4'($urandom_range(0, 15));
        so = 4'($urandom_range(0, 15));
      end
      addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'($urandom_range(0, 3));
      rr = ($urandom_range(0, 7) == 0) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      br = ($urandom_range(0, 7) == 0) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      do_txn(addr, $urandom, lo, so, $urandom, rr, br,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), lat);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
